// File: rtl/sar_search_8bit.sv
// Successive-approximation search controller: drives the B operand of an external
// magnitude comparator and rebuilds the unknown A operand MSB first from gt/eq/lt.
module sar_search_8bit #(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] probe,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found_eq,
  output logic         err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MSB = ONE << (W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  acc_r, acc_s;
  logic [KW-1:0] k_r, k_s;
  logic [W-1:0]  probe_r, probe_s;
  logic [W-1:0]  result_r, result_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          found_r, found_s;
  logic          err_r, err_s;
  logic [W-1:0]  acc_keep_s;

  function automatic logic is_one_hot(input logic [2:0] v);
    case (v)
      3'b100, 3'b010, 3'b001: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      k_r      <= '0;
      probe_r  <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      found_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      k_r      <= k_s;
      probe_r  <= probe_s;
      result_r <= result_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      found_r  <= found_s;
      err_r    <= err_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    k_s        = k_r;
    probe_s    = probe_r;
    result_s   = result_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    found_s    = found_r;
    err_s      = err_r;
    // gt keeps bit k; eq keeps it too when the search runs to completion
    acc_keep_s = (cmp_gt || cmp_eq) ? probe_r : acc_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = SEARCH;
          acc_s    = '0;
          k_s      = KW'(W - 1);
          probe_s  = MSB;
          result_s = '0;
          found_s  = 1'b0;
          err_s    = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s = IDLE;
          probe_s = '0;
          busy_s  = 1'b0;
        end
      end
      SEARCH: begin
        if (!is_one_hot({cmp_gt, cmp_eq, cmp_lt})) begin
          state_s  = IDLE;
          probe_s  = '0;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          result_s = '0;
          err_s    = 1'b1;
        end else if (cmp_eq && EARLY_EXIT) begin
          state_s  = IDLE;
          probe_s  = '0;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          result_s = probe_r;
          found_s  = 1'b1;
        end else if (k_r != '0) begin
          acc_s   = acc_keep_s;
          k_s     = k_r - KW'(1);
          probe_s = acc_keep_s | (ONE << (k_r - KW'(1)));
        end else begin
          acc_s    = acc_keep_s;
          state_s  = IDLE;
          probe_s  = '0;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          result_s = acc_keep_s;
          found_s  = cmp_eq;
        end
      end
      default: begin
        state_s = IDLE;
        probe_s = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign probe    = probe_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign found_eq = found_r;
  assign err      = err_r;

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit: two instances (early exit on/off), each answered
// by a behavioural comparator, with a result scoreboard filled at start, drained at done.
module tb_sar_search_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] probe_a, probe_b, result_a, result_b;
  logic       gt_a, eq_a, lt_a, gt_b, eq_b, lt_b;
  logic       busy_a, busy_b, done_a, done_b, found_a, found_b, err_a, err_b;
  logic [7:0] target_a, target_b;
  logic       fault_en;
  logic [7:0] fault_probe;
  logic       sel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] res;
    logic       feq;
    logic       er;
    int         np;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Comparator models; a fault forces the illegal vector 110 on one chosen probe value
  assign {gt_a, eq_a, lt_a} = (fault_en && probe_a == fault_probe) ? 3'b110 :
                              {target_a > probe_a, target_a == probe_a, target_a < probe_a};
  assign {gt_b, eq_b, lt_b} = (fault_en && probe_b == fault_probe) ? 3'b110 :
                              {target_b > probe_b, target_b == probe_b, target_b < probe_b};

  sar_search_8bit #(.W(8), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst), .start(start_a), .probe(probe_a),
    .cmp_gt(gt_a), .cmp_eq(eq_a), .cmp_lt(lt_a),
    .busy(busy_a), .done(done_a), .result(result_a), .found_eq(found_a), .err(err_a)
  );

  sar_search_8bit #(.W(8), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .start(start_b), .probe(probe_b),
    .cmp_gt(gt_b), .cmp_eq(eq_b), .cmp_lt(lt_b),
    .busy(busy_b), .done(done_b), .result(result_b), .found_eq(found_b), .err(err_b)
  );

  wire [7:0] o_probe  = sel ? probe_b  : probe_a;
  wire [7:0] o_result = sel ? result_b : result_a;
  wire       o_busy   = sel ? busy_b   : busy_a;
  wire       o_done   = sel ? done_b   : done_a;
  wire       o_found  = sel ? found_b  : found_a;
  wire       o_err    = sel ? err_b    : err_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference binary search over an ideal comparator
  task automatic model(input logic [7:0] tgt, input bit ee, input int fault_n,
                       output logic [7:0][7:0] pr, output int np,
                       output logic [7:0] res, output logic feq, output logic er);
    logic [7:0] acc, p;
    acc = 8'h00; pr = '0; np = 0; res = 8'h00; feq = 1'b0; er = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = acc | (8'h80 >> i);
      pr[i] = p;
      np = i + 1;
      if (np == fault_n) begin
        er = 1'b1;
        return;
      end
      if (ee && tgt == p) begin
        res = p; feq = 1'b1;
        return;
      end
      if (tgt >= p) acc = p;
      feq = (tgt == p);
    end
    res = acc;
  endtask

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  task automatic search(input bit b, input logic [7:0] tgt, input int fault_n, input bit hold);
    logic [7:0][7:0] pr;
    int np, n;
    logic [7:0] res;
    logic feq, er;
    bit got;
    exp_t e;
    model(tgt, !b, fault_n, pr, np, res, feq, er);
    sb.push_back('{res, feq, er, np});
    sel = b;
    if (b) target_b = tgt;
    else   target_a = tgt;
    fault_en    = (fault_n > 0);
    fault_probe = (fault_n > 0) ? pr[fault_n-1] : 8'h00;
    set_start(b, 1'b1);
    tick();
    if (!hold) set_start(b, 1'b0);
    n = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (o_done) begin
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("found_eq", o_found, e.feq);
        check("err", o_err, e.er);
        check("probe_count", n, e.np);
        check("probe_idle", o_probe, 8'h00);
        check("busy_fall", o_busy, 1'b0);
        got = 1;
        set_start(b, 1'b0);
      end else begin
        if (n == 0) begin
          check("clr_result", o_result, 8'h00);
          check("clr_found", o_found, 1'b0);
          check("clr_err", o_err, 1'b0);
        end
        check("busy", o_busy, 1'b1);
        check("probe", o_probe, (n < 8) ? pr[n] : 8'hxx);
        n++;
        tick();
      end
    end
    if (!got) check("done_timeout", 1'b0, 1'b1);
    fault_en = 1'b0;
    tick();
    check("done_pulse", o_done, 1'b0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    target_a = 8'h00; target_b = 8'h00; fault_en = 1'b0; fault_probe = 8'h00;
    tick(); tick();
    check("rst_probe", probe_a, 8'h00);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_result", result_a, 8'h00);
    check("rst_found", found_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_probe_b", probe_b, 8'h00);
    rst = 1'b0;
    tick();

    search(1'b0, 8'h00, 0, 1'b0);
    search(1'b0, 8'hA5, 0, 1'b0);
    search(1'b0, 8'h80, 0, 1'b0);
    search(1'b1, 8'h80, 0, 1'b0);
    search(1'b1, 8'h3C, 0, 1'b0);
    search(1'b0, 8'h3C, 3, 1'b0);
    search(1'b0, 8'h3C, 0, 1'b0);
    search(1'b0, 8'h5A, 0, 1'b1);
    sel = 1'b0;
    tick();
    check("hold_no_restart", busy_a, 1'b0);

    // Back-to-back 1-probe searches, second start in the done cycle
    target_a = 8'h80;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("b2b_busy1", busy_a, 1'b1);
    check("b2b_probe1", probe_a, 8'h80);
    tick();
    check("b2b_done1", done_a, 1'b1);
    check("b2b_res1", result_a, 8'h80);
    check("b2b_idle1", busy_a, 1'b0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("b2b_busy2", busy_a, 1'b1);
    check("b2b_nodone", done_a, 1'b0);
    tick();
    check("b2b_done2", done_a, 1'b1);
    check("b2b_found2", found_a, 1'b1);
    tick();

    // Reset during the 4th probe
    target_a = 8'h5A;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_probe", probe_a, 8'h00);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    check("mid_rst_result", result_a, 8'h00);
    check("mid_rst_flags", {found_a, err_a}, 2'b00);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a) seen = 1;
    end
    check("mid_rst_no_done", seen, 1'b0);
    search(1'b0, 8'hFF, 0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
